// File: rtl/soc_uart_slave.sv
// soc_uart_slave: memory-mapped UART (TXDATA/RXDATA/STATUS/BAUD_DIV) on the core data bus, with a small TX FIFO.
// Latency: zero-wait grant; response (rvalid/rdata) one cycle after every granted request.
// Backpressure: none on the bus; TX pushes into a full FIFO are dropped and flagged in tx_ovf.
// Optional even parity bit in both directions: define SOC_UART_PARITY_EN.
module soc_uart_slave #(
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd433,
    parameter int          TX_FIFO_DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    input  logic        UART0_rx,
    output logic        UART0_tx
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
`ifdef SOC_UART_PARITY_EN
        , S_PARITY
`endif
    } uart_state_t;

    // Bus decode: only addr[3:2] selects a register.
    logic [1:0] reg_sel;
    logic       wr_en, rd_en, tx_push_req, rx_read, stat_clr;
    logic [3:0] clr;
    logic       unused_bits;
    assign reg_sel     = data_addr[3:2];
    assign data_gnt    = data_req & ~rst_i;
    assign wr_en       = data_req & data_we;
    assign rd_en       = data_req & ~data_we;
    assign tx_push_req = wr_en && reg_sel == 2'd0 && data_be[0];
    assign rx_read     = rd_en && reg_sel == 2'd1;
    assign stat_clr    = wr_en && reg_sel == 2'd2 && data_be[0];
    assign clr         = stat_clr ? data_wdata[7:4] : 4'h0;
    assign unused_bits = ^{data_addr[31:4], data_addr[1:0], data_be[3:2], data_wdata[31:16]};

    logic [15:0] baud_div;
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_ovr, frame_err, parity_err, tx_ovf;

    // TX FIFO: pointers carry an extra wrap bit to tell full from empty.
    logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_full, fifo_empty, fifo_push, tx_pop, tx_ovf_set;
    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is then still accepted.
    assign fifo_push  = tx_push_req && (!fifo_full || tx_pop);
    assign tx_ovf_set = tx_push_req && fifo_full && !tx_pop;

    // FIFO storage write; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= data_wdata[7:0];
    end

    // FIFO pointer update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (tx_pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // TX FSM: each bit lasts tx_len+1 clocks; tx_len is reloaded from baud_div at every bit boundary.
    uart_state_t tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_len, tx_len_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_line, tx_tick;
    assign tx_tick  = tx_cnt == tx_len;
    assign UART0_tx = tx_line;

    // TX state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_len   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_len   <= tx_len_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    // TX next-state, FIFO pop and serial line level.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_len_n   = tx_len;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_n = '0;
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = fifo_mem[rd_ptr[AW-1:0]];
                    tx_len_n   = baud_div;
                    tx_state_n = S_START;
                end
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_tick) begin
                    tx_cnt_n   = '0;
                    tx_len_n   = baud_div;
                    tx_bit_n   = '0;
                    tx_state_n = S_DATA;
                end
            end
            S_DATA: begin
                tx_line = tx_shift[tx_bit];
                if (tx_tick) begin
                    tx_cnt_n = '0;
                    tx_len_n = baud_div;
                    tx_bit_n = tx_bit + 3'd1;
`ifdef SOC_UART_PARITY_EN
                    if (tx_bit == 3'd7) tx_state_n = S_PARITY;
`else
                    if (tx_bit == 3'd7) tx_state_n = S_STOP;
`endif
                end
            end
`ifdef SOC_UART_PARITY_EN
            S_PARITY: begin
                tx_line = ^tx_shift;
                if (tx_tick) begin
                    tx_cnt_n   = '0;
                    tx_len_n   = baud_div;
                    tx_state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tx_tick) begin
                    tx_cnt_n = '0;
                    tx_len_n = baud_div;
                    if (!fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = fifo_mem[rd_ptr[AW-1:0]];
                        tx_state_n = S_START;
                    end else begin
                        tx_state_n = S_IDLE;
                    end
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // RX synchronizer plus one edge-detect flop; idle line level is 1.
    logic rx_s1, rx_s2, rx_prev, rx_fall;
    assign rx_fall = rx_prev & ~rx_s2;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= UART0_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX FSM: start bit sampled at half a bit, later bits one full bit apart.
    uart_state_t rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_len, rx_len_n;
    logic [16:0] rx_half, rx_cnt1;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_done, rx_ferr, rx_perr, rx_tick;
    assign rx_half = ({1'b0, rx_len} + 17'd1) >> 1;
    assign rx_cnt1 = {1'b0, rx_cnt} + 17'd1;
    assign rx_tick = rx_cnt == rx_len;

    // RX state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_len   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_len   <= rx_len_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // RX next-state and completion/error strobes.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_len_n   = rx_len;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        rx_perr    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (rx_fall) begin
                    rx_len_n   = baud_div;
                    rx_state_n = S_START;
                end
            end
            S_START: begin
                if (rx_cnt1 >= rx_half) begin
                    rx_cnt_n   = '0;
                    rx_len_n   = baud_div;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_cnt_n   = '0;
                    rx_len_n   = baud_div;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
`ifdef SOC_UART_PARITY_EN
                    if (rx_bit == 3'd7) rx_state_n = S_PARITY;
`else
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
`endif
                end
            end
`ifdef SOC_UART_PARITY_EN
            S_PARITY: begin
                if (rx_tick) begin
                    rx_cnt_n   = '0;
                    rx_len_n   = baud_div;
                    rx_perr    = rx_s2 != ^rx_shift;
                    rx_state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (rx_tick) begin
                    rx_done    = 1'b1;
                    rx_ferr    = ~rx_s2;
                    rx_state_n = S_IDLE;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // Status flags and RX holding register; a new event wins over a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_ovr     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            tx_ovf     <= 1'b0;
        end else begin
            rx_ovr     <= (rx_ovr & ~clr[0]) | (rx_done & rx_valid & ~rx_read);
            frame_err  <= (frame_err & ~clr[1]) | (rx_done & rx_ferr);
            parity_err <= (parity_err & ~clr[2]) | rx_perr;
            tx_ovf     <= (tx_ovf & ~clr[3]) | tx_ovf_set;
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Baud divider, byte-lane writable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            baud_div <= DEFAULT_BAUD_DIV;
        end else if (wr_en && reg_sel == 2'd3) begin
            if (data_be[0]) baud_div[7:0]  <= data_wdata[7:0];
            if (data_be[1]) baud_div[15:8] <= data_wdata[15:8];
        end
    end

    logic [7:0]  status;
    logic [31:0] rd_mux;
    assign status = {tx_ovf, parity_err, frame_err, rx_ovr, rx_valid,
                     tx_state != S_IDLE, fifo_empty, fifo_full};

    // Read data mux.
    always_comb begin
        rd_mux = 32'h0;
        case (reg_sel)
            2'd1:    rd_mux = {24'h0, rx_byte};
            2'd2:    rd_mux = {24'h0, status};
            2'd3:    rd_mux = {16'h0, baud_div};
            default: rd_mux = 32'h0;
        endcase
    end

    // Bus response: one-cycle rvalid, rdata zero except in read responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_rvalid <= 1'b0;
            data_rdata  <= 32'h0;
        end else begin
            data_rvalid <= data_req;
            data_rdata  <= rd_en ? rd_mux : 32'h0;
        end
    end
endmodule

// File: tb/tb_soc_uart_slave.sv
// Testbench for soc_uart_slave: bus protocol, TX framing/FIFO, RX framing/flags, reset.
// TX/RX bytes go through expected-value queues filled when stimulus is driven.
`timescale 1ns/1ps
module tb_soc_uart_slave;
`ifdef SOC_UART_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req, data_we;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_be;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        UART0_rx, UART0_tx;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    soc_uart_slave dut (
        .clk_i(clk), .rst_i(rst),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
        .data_be(data_be), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .UART0_rx(UART0_rx), .UART0_tx(UART0_tx)
    );

    always #5 clk = ~clk;

    function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
        logic [NB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (PAR) f[9] = ^b;
        return f;
    endfunction

    // One bus transaction starting at a negedge; returns at the next negedge with the response.
    task automatic bus_op(input logic we, input logic [1:0] sel, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic vld, output logic gnt);
        data_req   = 1'b1;
        data_we    = we;
        data_addr  = $urandom();
        data_addr[3:2] = sel;
        data_be    = be;
        data_wdata = wd;
        #1 gnt = data_gnt;
        @(negedge clk);
        vld = data_rvalid;
        rd  = data_rdata;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_wdata = 32'h0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] wd);
        logic [31:0] r; logic v, g;
        bus_op(1'b1, sel, 4'hF, wd, r, v, g);
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] val);
        logic v, g;
        bus_op(1'b0, sel, 4'h0, 32'h0, val, v, g);
    endtask

    // Waits (bounded) for a start bit and samples every clock of the frame.
    task automatic capture_frame(output logic [NB-1:0] bits, output bit stable, output int wc);
        wc = 0; stable = 1'b1; bits = '1;
        @(negedge clk);
        while (UART0_tx !== 1'b0 && wc < 400) begin
            wc++;
            @(negedge clk);
        end
        if (UART0_tx !== 1'b0) begin
            stable = 1'b0;
            return;
        end
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < CPB; j++) begin
                if (i != 0 || j != 0) @(negedge clk);
                if (j == 0) bits[i] = UART0_tx;
                else if (UART0_tx !== bits[i]) stable = 1'b0;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input logic par_bad);
        logic [NB-1:0] f;
        f = frame_of(b);
        f[NB-1] = stop;
        f[NB-2] = f[NB-2] ^ (PAR & par_bad);
        exp_rx.push_back(b);
        for (int i = 0; i < NB; i++)
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                UART0_rx = f[i];
            end
        @(negedge clk);
        UART0_rx = 1'b1;
    endtask

    task automatic rx_poll(output logic [31:0] st);
        for (int i = 0; i < 40; i++) begin
            rd(2'd2, st);
            if (st[3]) break;
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1; data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8;
        data_be = 4'h0; data_wdata = 32'h0; UART0_rx = 1'b1;
        #1;
        total++; if (data_gnt !== 1'b0) begin bad++; $display("FAIL gnt_in_reset got=%b want=0", data_gnt); end
        total++; if (UART0_tx !== 1'b1) begin bad++; $display("FAIL tx_in_reset got=%b want=1", UART0_tx); end
        total++; if (data_rvalid !== 1'b0 || data_rdata !== 32'h0) begin bad++;
            $display("FAIL resp_in_reset got=%b/%h want=0/0", data_rvalid, data_rdata); end
        data_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(2'd2, r);
        total++; if (r !== 32'h02) begin bad++; $display("FAIL reset_status got=%h want=00000002", r); end
        rd(2'd3, r);
        total++; if (r !== 32'd433) begin bad++; $display("FAIL reset_baud got=%h want=%h", r, 32'd433); end
    endtask

    task automatic test_bus();
        logic [31:0] r; logic v, g;
        bus_op(1'b1, 2'd3, 4'b0011, 32'hABCD0003, r, v, g);
        total++; if (g !== 1'b1 || v !== 1'b1 || r !== 32'h0) begin bad++;
            $display("FAIL write_resp got gnt=%b rvalid=%b rdata=%h want 1/1/0", g, v, r); end
        bus_op(1'b1, 2'd3, 4'b0010, 32'h00001200, r, v, g);
        rd(2'd3, r);
        total++; if (r !== 32'h1203) begin bad++; $display("FAIL baud_lane got=%h want=00001203", r); end
        bus_op(1'b1, 2'd3, 4'b0011, 32'h00000003, r, v, g);
        // three back-to-back reads, then an idle cycle
        for (int i = 0; i < 3; i++) begin
            bus_op(1'b0, 2'd3, 4'h0, 32'h0, r, v, g);
            total++; if (v !== 1'b1 || r !== 32'h3) begin bad++;
                $display("FAIL b2b_read%0d got rvalid=%b rdata=%h want 1/00000003", i, v, r); end
        end
        @(negedge clk);
        total++; if (data_rvalid !== 1'b0 || data_rdata !== 32'h0) begin bad++;
            $display("FAIL idle_resp got=%b/%h want=0/0", data_rvalid, data_rdata); end
        rd(2'd0, r);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h want=0", r); end
        bus_op(1'b1, 2'd0, 4'b1110, 32'h000000FF, r, v, g);
        repeat (3) @(negedge clk);
        rd(2'd2, r);
        total++; if (r !== 32'h02) begin bad++; $display("FAIL be0_low_nopush got=%h want=00000002", r); end
    endtask

    task automatic test_tx();
        logic [31:0] r; logic v, g; logic [NB-1:0] bits; bit st; int wc; logic [7:0] e;
        bus_op(1'b1, 2'd0, 4'h1, 32'h123456A5, r, v, g);
        exp_tx.push_back(8'hA5);
        total++; if (g !== 1'b1 || v !== 1'b1) begin bad++; $display("FAIL tx_write_handshake got gnt=%b rvalid=%b want 1/1", g, v); end
        capture_frame(bits, st, wc);
        e = exp_tx.pop_front();
        total++; if (!st || bits !== frame_of(e)) begin bad++;
            $display("FAIL tx_frame got=%b stable=%0d want=%b", bits, st, frame_of(e)); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (UART0_tx !== 1'b1) st = 1'b0;
        end
        total++; if (!st) begin bad++; $display("FAIL tx_idle got=0 want=1"); end
        rd(2'd2, r);
        total++; if (r !== 32'h02) begin bad++; $display("FAIL tx_done_status got=%h want=00000002", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic v, g;
        logic [7:0] bytes [6];
        bytes = '{8'h3A, 8'hC5, 8'h01, 8'h80, 8'h7E, 8'hEE};
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bus_op(1'b1, 2'd0, 4'h1, {24'h0, bytes[i]}, r, v, g);
                    if (i < 5) exp_tx.push_back(bytes[i]);
                end
                rd(2'd2, r);
                total++; if (r !== 32'h85) begin bad++; $display("FAIL full_status got=%h want=00000085", r); end
            end
            begin
                logic [NB-1:0] bits; bit st; int wc; logic [7:0] e;
                for (int k = 0; k < 5; k++) begin
                    capture_frame(bits, st, wc);
                    e = (exp_tx.size() != 0) ? exp_tx.pop_front() : 8'hXX;
                    total++; if (!st || bits !== frame_of(e)) begin bad++;
                        $display("FAIL b2b_frame%0d got=%b stable=%0d want=%b", k, bits, st, frame_of(e)); end
                    if (k > 0) begin
                        total++; if (wc != 0) begin bad++; $display("FAIL b2b_gap%0d got=%0d want=0", k, wc); end
                    end
                end
            end
        join
        repeat (8) @(negedge clk);
        total++; if (exp_tx.size() != 0 || UART0_tx !== 1'b1) begin bad++;
            $display("FAIL b2b_extra got queue=%0d tx=%b want 0/1", exp_tx.size(), UART0_tx); end
        wr(2'd2, 32'h80);
        rd(2'd2, r);
        total++; if (r !== 32'h02) begin bad++; $display("FAIL ovf_clear got=%h want=00000002", r); end
    endtask

    task automatic test_rx();
        logic [31:0] r; logic [7:0] e;
        send_rx(8'h3C, 1'b1, 1'b0);
        rx_poll(r);
        total++; if (r !== 32'h0A) begin bad++; $display("FAIL rx_valid_status got=%h want=0000000a", r); end
        rd(2'd1, r);
        e = exp_rx.pop_front();
        total++; if (r !== {24'h0, e}) begin bad++; $display("FAIL rx_data got=%h want=%h", r, {24'h0, e}); end
        rd(2'd2, r);
        total++; if (r !== 32'h02) begin bad++; $display("FAIL rx_read_clears got=%h want=00000002", r); end
        // two bytes without a read: second overwrites and flags overrun
        send_rx(8'h5A, 1'b1, 1'b0);
        send_rx(8'h81, 1'b1, 1'b0);
        rx_poll(r);
        repeat (4) @(negedge clk);
        rd(2'd2, r);
        total++; if (r !== 32'h1A) begin bad++; $display("FAIL overrun_status got=%h want=0000001a", r); end
        rd(2'd1, r);
        e = exp_rx.pop_back();
        exp_rx.delete();
        total++; if (r !== {24'h0, e}) begin bad++; $display("FAIL overrun_data got=%h want=%h", r, {24'h0, e}); end
        wr(2'd2, 32'h10);
        rd(2'd2, r);
        total++; if (r !== 32'h02) begin bad++; $display("FAIL overrun_clear got=%h want=00000002", r); end
        // short low glitch must be ignored
        @(negedge clk); UART0_rx = 1'b0;
        repeat (2) @(negedge clk); UART0_rx = 1'b1;
        repeat (20) @(negedge clk);
        rd(2'd2, r);
        total++; if (r !== 32'h02) begin bad++; $display("FAIL glitch got=%h want=00000002", r); end
        // stop bit low: frame error, byte still stored
        send_rx(8'h55, 1'b0, 1'b0);
        rx_poll(r);
        total++; if (r !== 32'h2A) begin bad++; $display("FAIL frame_err_status got=%h want=0000002a", r); end
        rd(2'd1, r);
        e = exp_rx.pop_front();
        total++; if (r !== {24'h0, e}) begin bad++; $display("FAIL frame_err_data got=%h want=%h", r, {24'h0, e}); end
        wr(2'd2, 32'h20);
        rd(2'd2, r);
        total++; if (r !== 32'h02) begin bad++; $display("FAIL frame_err_clear got=%h want=00000002", r); end
    endtask

`ifdef SOC_UART_PARITY_EN
    task automatic test_parity();
        logic [31:0] r; logic [NB-1:0] bits; bit st; int wc; logic [7:0] e;
        wr(2'd0, 32'h07);
        exp_tx.push_back(8'h07);
        capture_frame(bits, st, wc);
        e = exp_tx.pop_front();
        total++; if (!st || bits !== frame_of(e) || bits[9] !== 1'b1) begin bad++;
            $display("FAIL parity_tx got=%b want=%b", bits, frame_of(e)); end
        send_rx(8'h07, 1'b1, 1'b1);
        rx_poll(r);
        total++; if (r !== 32'h4A) begin bad++; $display("FAIL parity_err_status got=%h want=0000004a", r); end
        rd(2'd1, r);
        e = exp_rx.pop_front();
        total++; if (r !== {24'h0, e}) begin bad++; $display("FAIL parity_err_data got=%h want=%h", r, {24'h0, e}); end
        wr(2'd2, 32'h40);
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [31:0] r; bit st;
        wr(2'd0, 32'h55);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (UART0_tx !== 1'b1 || data_rvalid !== 1'b0) begin bad++;
            $display("FAIL mid_reset got tx=%b rvalid=%b want 1/0", UART0_tx, data_rvalid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(2'd2, r);
        total++; if (r !== 32'h02) begin bad++; $display("FAIL mid_reset_status got=%h want=00000002", r); end
        rd(2'd3, r);
        total++; if (r !== 32'd433) begin bad++; $display("FAIL mid_reset_baud got=%h want=%h", r, 32'd433); end
        st = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (UART0_tx !== 1'b1) st = 1'b0;
        end
        total++; if (!st) begin bad++; $display("FAIL mid_reset_line got=0 want=1"); end
    endtask

    initial begin
        test_reset();
        test_bus();
        test_tx();
        test_back_to_back();
        test_rx();
`ifdef SOC_UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/soc_uart_slave.md
SOC_UART_SLAVE -- requirements
Module: soc_uart_slave

Interface
REQ-001 SHALL have parameter DEFAULT_BAUD_DIV, default 16'd433, meaning reset value of BAUD_DIV (clocks per bit minus 1).
REQ-002 SHALL have parameter TX_FIFO_DEPTH, default 4, meaning TX FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk_i  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports data_req input 1, data_addr input 32, data_we input 1, data_be input 4, data_wdata input 32; core data bus request, Slave side of the core data interface.
REQ-006 SHALL have ports data_gnt output 1, data_rvalid output 1, data_rdata output 32; core data bus response.
REQ-007 SHALL have ports UART0_rx input 1 (serial in, asynchronous) and UART0_tx output 1 (serial out).

Function
REQ-008 SHALL decode only data_addr[3:2]; upstream interconnect selects this block: 0=TXDATA, 1=RXDATA, 2=STATUS, 3=BAUD_DIV.
REQ-009 SHALL drive data_gnt = data_req combinationally (zero-wait grant), and 0 while rst_i is high.
REQ-010 SHALL assert data_rvalid for exactly one cycle, one cycle after every granted request (read or write); back-to-back requests yield back-to-back rvalid.
REQ-011 SHALL drive data_rdata with read data in the rvalid cycle, and 32'h0 in all other cycles and for write responses.
REQ-012 TXDATA write with data_be[0]=1 SHALL push data_wdata[7:0] into the TX FIFO; push when full is dropped and sets STATUS.tx_ovf, except when a pop occurs in the same cycle (then accepted). Reads return 0.
REQ-013 RXDATA read SHALL return {24'h0, rx_byte} and clear rx_valid; if a new byte completes in the same cycle, the new byte is stored, rx_valid stays 1, and no overrun is flagged.
REQ-014 STATUS bits SHALL be: 0 tx_full, 1 tx_empty, 2 tx_busy, 3 rx_valid, 4 rx_overrun, 5 frame_err, 6 parity_err, 7 tx_ovf; bits 4-7 are write-1-to-clear (be[0]); the others are read-only.
REQ-015 BAUD_DIV SHALL be a 16-bit register written per byte lane be[1:0]; a write mid-frame takes effect at the next bit boundary.
REQ-016 Every serial bit SHALL last BAUD_DIV+1 clocks; frame = start(0), 8 data bits LSB first, optional parity (REQ-023), 1 stop(1).
REQ-017 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START when FIFO non-empty (pop on entry); after STOP, proceed to START directly if FIFO non-empty, else IDLE; tx_busy=1 outside IDLE; UART0_tx=1 in IDLE.
REQ-018 RX SHALL pass UART0_rx through a 2-flop synchronizer; RX FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 RX SHALL leave IDLE on a synchronized falling edge, sample start at (BAUD_DIV+1)/2 clocks, and return to IDLE without flags if it samples 1 (glitch); later bits are sampled every BAUD_DIV+1 clocks.
REQ-020 STOP sampled 0 SHALL set frame_err, still store the byte; completing a byte while rx_valid=1 SHALL set rx_overrun and overwrite rx_byte.

Reset
REQ-021 rst_i high SHALL asynchronously force: UART0_tx=1, data_rvalid=0, data_rdata=0, both FSMs IDLE, TX FIFO empty, rx_valid and all sticky flags 0, BAUD_DIV=DEFAULT_BAUD_DIV, synchronizer flops 1.
REQ-022 Reset mid-frame SHALL abort the frame immediately; a pending rvalid is discarded; no partial byte is stored.

Configuration
REQ-023 Macro SOC_UART_PARITY_EN defined SHALL insert an even-parity bit after data in TX and RX; an RX parity mismatch sets parity_err and still stores the byte. Undefined: no PARITY state, 10-bit frames, STATUS bit 6 reads 0.

Verification (BAUD_DIV=3, i.e. 4 clocks/bit, SOC_UART_PARITY_EN undefined unless stated)
REQ-024 Write TXDATA 0xA5 -> gnt same cycle, rvalid next cycle; UART0_tx shows 0,1,0,1,0,0,1,0,1,1 for 4 clocks each (40 clocks), then idle 1.
REQ-025 Write 5 bytes back-to-back with TX idle -> first pops at once, 4 queued, none dropped, frames contiguous; a 6th write while full and no pop -> dropped, STATUS=0x85 (tx_ovf|tx_busy|tx_full).
REQ-026 Drive 0x3C on UART0_rx -> rx_valid=1; RXDATA read returns 0x0000003C, STATUS bit 3 then 0; second byte without read -> rx_overrun=1; write STATUS 0x10 clears it.
REQ-027 2-clock low glitch on UART0_rx -> no byte, no flags; stop bit driven 0 -> frame_err=1 and byte stored.
REQ-028 With SOC_UART_PARITY_EN: TX 0x07 -> parity bit 1 (11-bit frame); RX 0x07 with parity bit 0 -> parity_err=1.
REQ-029 Assert rst_i mid-TX-frame -> UART0_tx=1 same cycle, STATUS reads 0x02 after release, BAUD_DIV reads DEFAULT_BAUD_DIV.
